rs_mul: RTL and testbench

RS_MUL -- requirements
Module: rs_mul

---
 rtl/sys_defs.sv | 34 +++
 rtl/rs_mul_psel.sv | 15 +
 rtl/rs_mul.sv | 220 ++++++++++++++++++++++
 tb/tb_rs_mul.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sys_defs.sv
// Shared definitions for the out-of-order core: datapath widths, the ALU
// function encoding used by the multiplier, and the MUL reservation-station
// packet that travels from dispatch to the multiplier.
package sys_defs;

  localparam int XLEN        = 32;
  localparam int PRF_LEN     = 6;
  localparam int ROB_LEN     = 5;
  localparam int RS_MUL_SIZE = 4;

  // Multiply flavours; ALU_MUL is zero so a cleared packet reads as a plain MUL.
  typedef enum logic [1:0] {
    ALU_MUL    = 2'd0,
    ALU_MULH   = 2'd1,
    ALU_MULHSU = 2'd2,
    ALU_MULHU  = 2'd3
  } ALU_FUNC;

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    ALU_FUNC            mul_func;
    logic [XLEN-1:0]    opa_value;
    logic [XLEN-1:0]    opb_value;
    logic [PRF_LEN-1:0] dest_preg_idx;
    logic [ROB_LEN-1:0] rob_idx;
  } RS_MUL_PACKET;

  // Issue-side state of the MUL station: one multiply in flight at most.
  typedef enum logic {
    RS_MUL_IDLE = 1'b0,
    RS_MUL_BUSY = 1'b1
  } rs_mul_state_e;

endpackage

// File: rtl/rs_mul_psel.sv
// Fixed-priority selector: grants the lowest-index asserted request as a
// one-hot vector. Shared by free-entry allocation and issue selection.
module rs_mul_psel #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] req,
  output logic [WIDTH-1:0] gnt
);

  // Isolate the lowest set bit: req & -req.
  always_comb begin
    gnt = req & (~req + 1'b1);
  end

endmodule

// File: rtl/rs_mul.sv
// MUL reservation station. Holds dispatched multiply instructions, captures
// operands from the CDB, and issues one ready entry at a time to a
// multi-cycle multiplier, holding the issued packet until it completes.
// Optional build macro: RS_MUL_OLDEST_FIRST_EN -- issue the oldest ready
// entry instead of the lowest-index one (adds a per-entry age counter).
module rs_mul #(
  parameter int RS_MUL_SIZE = sys_defs::RS_MUL_SIZE,
  parameter int RS_MUL_LEN  = $clog2(RS_MUL_SIZE)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         squash,
  input  logic                         dispatch_en,
  input  sys_defs::RS_MUL_PACKET       dispatch_packet,
  input  logic                         opa_ready,
  input  logic                         opb_ready,
  input  logic [sys_defs::PRF_LEN-1:0] opa_preg_idx,
  input  logic [sys_defs::PRF_LEN-1:0] opb_preg_idx,
  input  logic                         cdb_valid,
  input  logic [sys_defs::PRF_LEN-1:0] cdb_preg_idx,
  input  logic [sys_defs::XLEN-1:0]    cdb_value,
  input  logic                         mul_free,
  input  logic                         mul_valid,
  output sys_defs::RS_MUL_PACKET       rs_mul_packet,
  output logic                         mul_enable,
  output logic                         rs_mul_full
);

  import sys_defs::*;

  // Entry storage
  logic [RS_MUL_SIZE-1:0] busy;
  logic [RS_MUL_SIZE-1:0] opa_rdy;
  logic [RS_MUL_SIZE-1:0] opb_rdy;
  logic [PRF_LEN-1:0]     opa_tag   [RS_MUL_SIZE];
  logic [PRF_LEN-1:0]     opb_tag   [RS_MUL_SIZE];
  RS_MUL_PACKET           entry_pkt [RS_MUL_SIZE];

  // Issue side
  rs_mul_state_e          state, state_next;
  RS_MUL_PACKET           issue_pkt;
  logic                   issue_fire;
  logic [RS_MUL_SIZE-1:0] entry_ready;
  logic [RS_MUL_SIZE-1:0] issue_req;
  logic [RS_MUL_SIZE-1:0] issue_gnt;
  logic [RS_MUL_LEN-1:0]  issue_idx;

  // Dispatch side
  logic [RS_MUL_SIZE-1:0] free_vec;
  logic [RS_MUL_SIZE-1:0] alloc_gnt;
  logic                   dispatch_fire;
  RS_MUL_PACKET           disp_pkt;
  logic                   disp_opa_rdy;
  logic                   disp_opb_rdy;

  assign rs_mul_full   = &busy;
  assign free_vec      = ~busy;
  assign entry_ready   = busy & opa_rdy & opb_rdy;
  assign dispatch_fire = dispatch_en & ~rs_mul_full & ~squash;

  rs_mul_psel #(.WIDTH(RS_MUL_SIZE)) u_alloc_psel (
    .req (free_vec),
    .gnt (alloc_gnt)
  );

  rs_mul_psel #(.WIDTH(RS_MUL_SIZE)) u_issue_psel (
    .req (issue_req),
    .gnt (issue_gnt)
  );

`ifdef RS_MUL_OLDEST_FIRST_EN
  // age[i] = number of busy entries dispatched after entry i, so the oldest
  // busy entry has the largest age and all busy ages are distinct.
  logic [RS_MUL_LEN-1:0]  age [RS_MUL_SIZE];
  logic [RS_MUL_SIZE-1:0] older_than_issued;

  // Restrict issue requests to the single oldest ready entry.
  always_comb begin
    issue_req         = '0;
    older_than_issued = '0;
    for (int i = 0; i < RS_MUL_SIZE; i++) begin
      issue_req[i]         = entry_ready[i];
      older_than_issued[i] = issue_fire && (age[i] > age[issue_idx]);
      for (int j = 0; j < RS_MUL_SIZE; j++) begin
        if (entry_ready[j] && (age[j] > age[i])) issue_req[i] = 1'b0;
      end
    end
  end

  // Keep ages dense: new entries start at zero, older ones step up on each
  // dispatch and step down when a younger entry leaves.
  always_ff @(posedge clock) begin
    if (reset || squash) begin
      for (int i = 0; i < RS_MUL_SIZE; i++) age[i] <= '0;
    end else begin
      for (int i = 0; i < RS_MUL_SIZE; i++) begin
        if (dispatch_fire && alloc_gnt[i]) begin
          age[i] <= '0;
        end else if (busy[i]) begin
          case ({dispatch_fire, older_than_issued[i]})
            2'b10:   age[i] <= age[i] + 1'b1;
            2'b01:   age[i] <= age[i] - 1'b1;
            default: ;
          endcase
        end
      end
    end
  end
`else
  // Lowest-index ready entry wins.
  always_comb begin
    issue_req = entry_ready;
  end
`endif

  // Encode the one-hot issue grant into an index for the packet mux.
  always_comb begin
    issue_idx = '0;
    for (int i = 0; i < RS_MUL_SIZE; i++) begin
      if (issue_gnt[i]) issue_idx = RS_MUL_LEN'(i);
    end
  end

  // Dispatch-time operand capture, including a same-cycle CDB broadcast.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    disp_pkt     = dispatch_packet;
    disp_opa_rdy = opa_ready;
    disp_opb_rdy = opb_ready;
    if (!opa_ready && cdb_valid && (cdb_preg_idx == opa_preg_idx)) begin
      disp_pkt.opa_value = cdb_value;
      disp_opa_rdy       = 1'b1;
    end
    if (!opb_ready && cdb_valid && (cdb_preg_idx == opb_preg_idx)) begin
      disp_pkt.opb_value = cdb_value;
      disp_opb_rdy       = 1'b1;
    end
  end

  // Busy bits: set on dispatch, cleared on issue, wiped by squash or reset.
  // NOTE: sequential state uses non-blocking assignment so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clock) begin
    if (reset || squash) begin
      busy <= '0;
    end else begin
      for (int i = 0; i < RS_MUL_SIZE; i++) begin
        if (dispatch_fire && alloc_gnt[i]) busy[i] <= 1'b1;
        else if (issue_fire && issue_gnt[i]) busy[i] <= 1'b0;
      end
    end
  end

  // Entry payload: written on dispatch, operands filled in by CDB wakeup.
  // NOTE: the payload array is deliberately not reset; it is only ever read
  // through a busy bit, which is reset, so resetting it would buy nothing.
  always_ff @(posedge clock) begin
    for (int i = 0; i < RS_MUL_SIZE; i++) begin
      if (dispatch_fire && alloc_gnt[i]) begin
        entry_pkt[i] <= disp_pkt;
        opa_rdy[i]   <= disp_opa_rdy;
        opb_rdy[i]   <= disp_opb_rdy;
        opa_tag[i]   <= opa_preg_idx;
        opb_tag[i]   <= opb_preg_idx;
      end else if (busy[i]) begin
        if (!opa_rdy[i] && cdb_valid && (cdb_preg_idx == opa_tag[i])) begin
          entry_pkt[i].opa_value <= cdb_value;
          opa_rdy[i]             <= 1'b1;
        end
        if (!opb_rdy[i] && cdb_valid && (cdb_preg_idx == opb_tag[i])) begin
          entry_pkt[i].opb_value <= cdb_value;
          opb_rdy[i]             <= 1'b1;
        end
      end
    end
  end

  // Issue FSM next-state and start pulse; squash blocks any issue.
  always_comb begin
    state_next = state;
    mul_enable = 1'b0;
    issue_fire = 1'b0;
    case (state)
      RS_MUL_IDLE: begin
        if (!squash && mul_free && (|entry_ready)) begin
          issue_fire = 1'b1;
          mul_enable = 1'b1;
          state_next = RS_MUL_BUSY;
        end
      end
      RS_MUL_BUSY: begin
        if (mul_valid) state_next = RS_MUL_IDLE;
      end
      default: state_next = RS_MUL_IDLE;
    endcase
    if (squash) state_next = RS_MUL_IDLE;
  end

  // Issue FSM state register.
  always_ff @(posedge clock) begin
    if (reset) state <= RS_MUL_IDLE;
    else       state <= state_next;
  end

  // Issue register: captures the selected packet so the multiplier sees it
  // unchanged until completion, even after the entry is reused.
  always_ff @(posedge clock) begin
    if (reset)           issue_pkt <= '0;
    else if (issue_fire) issue_pkt <= entry_pkt[issue_idx];
  end

  // In the issue cycle, forward the entry being captured so the packet is
  // already valid alongside mul_enable; afterwards the register holds it.
  always_comb begin
    rs_mul_packet = issue_pkt;
    if (issue_fire) rs_mul_packet = entry_pkt[issue_idx];
  end

endmodule

// File: tb/tb_rs_mul.sv
// Self-checking bench for rs_mul: directed scenarios for the key behaviours
// followed by randomized traffic, all compared against a behavioural model
// of the station (entry list ordered by dispatch sequence number).
module tb_rs_mul;
  import sys_defs::*;

  logic               clock;
  logic               reset;
  logic               squash;
  logic               dispatch_en;
  RS_MUL_PACKET       dispatch_packet;
  logic               opa_ready, opb_ready;
  logic [PRF_LEN-1:0] opa_preg_idx, opb_preg_idx;
  logic               cdb_valid;
  logic [PRF_LEN-1:0] cdb_preg_idx;
  logic [XLEN-1:0]    cdb_value;
  logic               mul_free, mul_valid;
  RS_MUL_PACKET       rs_mul_packet;
  logic               mul_enable;
  logic               rs_mul_full;

  rs_mul dut (
    .clock           (clock),
    .reset           (reset),
    .squash          (squash),
    .dispatch_en     (dispatch_en),
    .dispatch_packet (dispatch_packet),
    .opa_ready       (opa_ready),
    .opb_ready       (opb_ready),
    .opa_preg_idx    (opa_preg_idx),
    .opb_preg_idx    (opb_preg_idx),
    .cdb_valid       (cdb_valid),
    .cdb_preg_idx    (cdb_preg_idx),
    .cdb_value       (cdb_value),
    .mul_free        (mul_free),
    .mul_valid       (mul_valid),
    .rs_mul_packet   (rs_mul_packet),
    .mul_enable      (mul_enable),
    .rs_mul_full     (rs_mul_full)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  typedef struct {
    bit                 valid;
    RS_MUL_PACKET       pkt;
    bit                 ra, rb;
    logic [PRF_LEN-1:0] ta, tb;
    longint unsigned    seq;
  } m_entry_t;

  m_entry_t        m_ent [RS_MUL_SIZE];
  bit              m_busy;
  bit              m_known = 0;
  RS_MUL_PACKET    m_held;
  longint unsigned m_seq = 0;
  bit              c_en;
  int              c_sel;

  function automatic bit m_full();
    bit f = 1;
    for (int i = 0; i < RS_MUL_SIZE; i++) if (!m_ent[i].valid) f = 0;
    return f;
  endfunction

  // Which entry the station should hand to the multiplier, or -1.
  function automatic int m_pick();
    int best = -1;
    for (int i = 0; i < RS_MUL_SIZE; i++) begin
      if (m_ent[i].valid && m_ent[i].ra && m_ent[i].rb) begin
`ifdef RS_MUL_OLDEST_FIRST_EN
        if (best < 0 || m_ent[i].seq < m_ent[best].seq) best = i;
`else
        if (best < 0) best = i;
`endif
      end
    end
    return best;
  endfunction

  task automatic m_update();
    bit full_pre;
    int slot;
    if (reset) begin
      foreach (m_ent[i]) m_ent[i].valid = 0;
      m_busy  = 0;
      m_held  = '0;
      m_known = 1;
    end else if (squash) begin
      foreach (m_ent[i]) m_ent[i].valid = 0;
      m_busy = 0;
    end else begin
      full_pre = m_full();
      slot = -1;
      for (int i = RS_MUL_SIZE - 1; i >= 0; i--) if (!m_ent[i].valid) slot = i;
      if (cdb_valid) begin
        foreach (m_ent[i]) begin
          if (m_ent[i].valid && !m_ent[i].ra && m_ent[i].ta == cdb_preg_idx) begin
            m_ent[i].ra = 1; m_ent[i].pkt.opa_value = cdb_value;
          end
          if (m_ent[i].valid && !m_ent[i].rb && m_ent[i].tb == cdb_preg_idx) begin
            m_ent[i].rb = 1; m_ent[i].pkt.opb_value = cdb_value;
          end
        end
      end
      if (c_en) begin
        m_held = m_ent[c_sel].pkt;
        m_ent[c_sel].valid = 0;
        m_busy = 1;
      end else if (m_busy && mul_valid) begin
        m_busy = 0;
      end
      if (dispatch_en && !full_pre) begin
        m_ent[slot].valid = 1;
        m_ent[slot].pkt   = dispatch_packet;
        m_ent[slot].ra    = opa_ready;
        m_ent[slot].rb    = opb_ready;
        m_ent[slot].ta    = opa_preg_idx;
        m_ent[slot].tb    = opb_preg_idx;
        m_ent[slot].seq   = m_seq++;
        if (!opa_ready && cdb_valid && cdb_preg_idx == opa_preg_idx) begin
          m_ent[slot].ra = 1; m_ent[slot].pkt.opa_value = cdb_value;
        end
        if (!opb_ready && cdb_valid && cdb_preg_idx == opb_preg_idx) begin
          m_ent[slot].rb = 1; m_ent[slot].pkt.opb_value = cdb_value;
        end
      end
    end
  endtask

  // One clock: compare outputs mid-cycle, then advance the model at the edge.
  task automatic tick();
    RS_MUL_PACKET exp_pkt;
    @(negedge clock);
    c_sel = m_pick();
    c_en  = !squash && !m_busy && mul_free && (c_sel >= 0);
    exp_pkt = m_held;
    if (c_en) exp_pkt = m_ent[c_sel].pkt;
    if (m_known) begin
      check("mul_enable", 128'(mul_enable), 128'(c_en));
      check("rs_mul_full", 128'(rs_mul_full), 128'(m_full()));
      check("rs_mul_packet", 128'(rs_mul_packet), 128'(exp_pkt));
    end
    @(posedge clock);
    m_update();
    #1;
  endtask

  // ---------------- stimulus helpers ----------------
  function automatic RS_MUL_PACKET make_pkt(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    RS_MUL_PACKET p;
    p.pc            = $urandom;
    p.mul_func      = ALU_FUNC'($urandom_range(0, 3));
    p.opa_value     = a;
    p.opb_value     = b;
    p.dest_preg_idx = PRF_LEN'($urandom);
    p.rob_idx       = ROB_LEN'($urandom);
    return p;
  endfunction

  task automatic quiet();
    reset = 0; squash = 0; dispatch_en = 0; cdb_valid = 0; mul_valid = 0;
    opa_ready = 1; opb_ready = 1; opa_preg_idx = '0; opb_preg_idx = '0;
    cdb_preg_idx = '0; cdb_value = '0;
  endtask

  task automatic dispatch(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                          input bit ra, input logic [PRF_LEN-1:0] ta);
    dispatch_en     = 1;
    dispatch_packet = make_pkt(a, b);
    opa_ready       = ra;
    opa_preg_idx    = ta;
    opb_ready       = 1;
    opb_preg_idx    = '0;
  endtask

  task automatic finish_mul();
    dispatch_en = 0; mul_free = 0; mul_valid = 1;
    tick();
    mul_valid = 0;
  endtask

  // Watchdog: the flow below is purely cycle-counted, this only guards a stall.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [XLEN-1:0] exp_val;
    quiet();
    mul_free = 0;
    dispatch_packet = '0;

    // Reset
    reset = 1;
    tick(); tick();
    reset = 0; mul_free = 1;
    #2;
    check("reset_en", 128'(mul_enable), 128'(0));
    check("reset_full", 128'(rs_mul_full), 128'(0));
    check("reset_pkt", 128'(rs_mul_packet), 128'(0));
    tick();

    // Ready operands 3 and 5 issue the next cycle and stay until mul_valid
    dispatch(32'd3, 32'd5, 1, '0);
    tick();
    dispatch_en = 0;
    #2;
    check("basic_en", 128'(mul_enable), 128'(1));
    check("basic_opa", 128'(rs_mul_packet.opa_value), 128'(3));
    check("basic_opb", 128'(rs_mul_packet.opb_value), 128'(5));
    tick(); tick();
    mul_valid = 1;
    #2;
    check("basic_hold_en", 128'(mul_enable), 128'(0));
    check("basic_hold_opa", 128'(rs_mul_packet.opa_value), 128'(3));
    check("basic_hold_opb", 128'(rs_mul_packet.opb_value), 128'(5));
    tick();
    mul_valid = 0;

    // CDB wakeup of a waiting operand
    dispatch(32'h0, 32'd7, 0, PRF_LEN'(7));
    tick();
    dispatch_en = 0;
    cdb_valid = 1; cdb_preg_idx = PRF_LEN'(7); cdb_value = 32'hFFFF_FFFE;
    #2;
    check("wake_wait_en", 128'(mul_enable), 128'(0));
    tick();
    cdb_valid = 0;
    #2;
    check("wake_en", 128'(mul_enable), 128'(1));
    check("wake_opa", 128'(rs_mul_packet.opa_value), 128'(32'hFFFF_FFFE));
    tick();
    finish_mul();

    // Dispatch colliding with a CDB broadcast of the same tag
    mul_free = 1;
    dispatch(32'h0, 32'd2, 0, PRF_LEN'(9));
    cdb_valid = 1; cdb_preg_idx = PRF_LEN'(9); cdb_value = 32'd42;
    tick();
    dispatch_en = 0; cdb_valid = 0;
    #2;
    check("collide_en", 128'(mul_enable), 128'(1));
    check("collide_opa", 128'(rs_mul_packet.opa_value), 128'(42));
    tick();
    finish_mul();

    // Fill, reject a fifth dispatch, release one issue
    mul_free = 0;
    for (int k = 0; k < RS_MUL_SIZE; k++) begin
      dispatch(32'd100 + 32'(k), 32'd2, 1, '0);
      #2;
      check("fill_not_full", 128'(rs_mul_full), 128'(0));
      tick();
    end
    dispatch(32'd99, 32'd2, 1, '0);
    #2;
    check("fill_full", 128'(rs_mul_full), 128'(1));
    tick();
    dispatch_en = 0; mul_free = 1;
    #2;
    check("fill_issue_en", 128'(mul_enable), 128'(1));
    check("fill_issue_opa", 128'(rs_mul_packet.opa_value), 128'(100));
    check("fill_still_full", 128'(rs_mul_full), 128'(1));
    tick();
    mul_free = 0;
    #2;
    check("fill_released", 128'(rs_mul_full), 128'(0));
    mul_free = 1; mul_valid = 1;
    for (int k = 0; k < 2 * RS_MUL_SIZE + 2; k++) tick();
    mul_valid = 0;
    #2;
    check("fill_drained", 128'(rs_mul_full), 128'(0));
    tick();

    // Issue order with an older entry at a higher index
    mul_free = 0;
    dispatch(32'h11, 32'd1, 1, '0);            tick();
    dispatch(32'h22, 32'd1, 0, PRF_LEN'(3));   tick();
    dispatch(32'h33, 32'd1, 1, '0);            tick();
    dispatch_en = 0; mul_free = 1;
    #2;
    check("order_first_opa", 128'(rs_mul_packet.opa_value), 128'(32'h11));
    tick();
    finish_mul();
    dispatch(32'h44, 32'd1, 1, '0);            tick();
    dispatch_en = 0; mul_free = 1;
`ifdef RS_MUL_OLDEST_FIRST_EN
    exp_val = 32'h33;
`else
    exp_val = 32'h44;
`endif
    #2;
    check("order_en", 128'(mul_enable), 128'(1));
    check("order_pick_opa", 128'(rs_mul_packet.opa_value), 128'(exp_val));
    tick();

    // Squash while busy with three entries held
    mul_free = 0;
    dispatch(32'h55, 32'd1, 1, '0);            tick();
    dispatch_en = 0; squash = 1; mul_free = 1;
    #2;
    check("squash_pre_full", 128'(rs_mul_full), 128'(0));
    check("squash_cycle_en", 128'(mul_enable), 128'(0));
    tick();
    squash = 0;
    #2;
    check("squash_empty_full", 128'(rs_mul_full), 128'(0));
    check("squash_empty_en", 128'(mul_enable), 128'(0));
    tick();
    mul_valid = 1;
    tick();
    mul_valid = 0;
    #2;
    check("squash_late_valid_en", 128'(mul_enable), 128'(0));
    dispatch(32'h66, 32'd1, 1, '0);            tick();
    dispatch_en = 0;
    #2;
    check("squash_idle_en", 128'(mul_enable), 128'(1));
    check("squash_idle_opa", 128'(rs_mul_packet.opa_value), 128'(32'h66));
    tick();

    // Reset abandons an in-flight multiply
    mul_free = 0; reset = 1;
    tick();
    reset = 0; mul_valid = 1;
    #2;
    check("inflight_reset_pkt", 128'(rs_mul_packet), 128'(0));
    tick();
    mul_valid = 0;
    dispatch(32'h88, 32'd1, 1, '0);            tick();
    dispatch_en = 0; mul_free = 1;
    #2;
    check("inflight_reset_en", 128'(mul_enable), 128'(1));
    check("inflight_reset_opa", 128'(rs_mul_packet.opa_value), 128'(32'h88));
    tick();
    finish_mul();

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      reset           = ($urandom_range(0, 199) == 0);
      squash          = ($urandom_range(0, 39) == 0);
      dispatch_en     = ($urandom_range(0, 1) == 1);
      dispatch_packet = make_pkt($urandom, $urandom);
      opa_ready       = ($urandom_range(0, 9) < 6);
      opb_ready       = ($urandom_range(0, 9) < 6);
      opa_preg_idx    = PRF_LEN'($urandom_range(0, 7));
      opb_preg_idx    = PRF_LEN'($urandom_range(0, 7));
      cdb_valid       = ($urandom_range(0, 9) < 4);
      cdb_preg_idx    = PRF_LEN'($urandom_range(0, 7));
      cdb_value       = $urandom;
      mul_free        = ($urandom_range(0, 9) < 7);
      mul_valid       = ($urandom_range(0, 9) < 3);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
